// File: rtl/neuron_step_sequencer.sv
// neuron_step_sequencer: bus initiator that runs one SNN timestep across a neuron bank.
// Define MEMBRANE_READBACK_EN to add a per-neuron membrane-voltage read into v_snapshot.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; inputs snapshotted on acceptance
// WR_I     | write input current to base(n)+0x14
// GAP      | one idle bus cycle between the two writes
// WR_CTL   | write {mode, reset=0, update=1} to base(n)+0x18
// SETTLE   | strobes low while the neuron starts its update
// POLL     | read status at base(n)+0x1C until not busy or poll limit
// RD_V     | gap cycle, then read membrane V at base(n)+0x20 (optional)
// NEXT     | advance neuron index or finish
// DONE     | one-cycle done pulse, busy low
module neuron_step_sequencer #(
    parameter int          NUM_NEURONS   = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          POLL_LIMIT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [32*NUM_NEURONS-1:0] input_currents,
    input  logic [NUM_NEURONS-1:0]    mode_bits,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_NEURONS-1:0]    spike_vector,
    output logic                      timeout_err,
    output logic [31:0]               addr,
    output logic                      write_en,
    output logic [31:0]               write_data,
    output logic                      read_en,
    input  logic [31:0]               read_data,
    input  logic                      busywait,
    output logic [32*NUM_NEURONS-1:0] v_snapshot
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    // At least one settle cycle is kept so the status read never follows the control write back-to-back.
    localparam logic [15:0] SETTLE_LOAD = (SETTLE_CYCLES > 1) ? 16'(SETTLE_CYCLES - 1) : 16'd0;
    localparam logic [15:0] POLL_LOAD   = (POLL_LIMIT > 1) ? 16'(POLL_LIMIT) : 16'd1;
    localparam logic [5:0]  OFS_I    = 6'h14;
    localparam logic [5:0]  OFS_CTL  = 6'h18;
    localparam logic [5:0]  OFS_STAT = 6'h1C;
    localparam logic [5:0]  OFS_V    = 6'h20;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_I,
        S_GAP,
        S_WR_CTL,
        S_SETTLE,
        S_POLL,
        S_RD_V,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          idx_inc;
    logic [15:0]               settle_q, settle_d;
    logic [15:0]               poll_q, poll_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [NUM_NEURONS-1:0]    spike_q, spike_d;
    logic                      timeout_q, timeout_d;
    logic [31:0]               addr_q, addr_d;
    logic                      we_q, we_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      re_q, re_d;
    logic [32*NUM_NEURONS-1:0] cur_q, cur_d;
    logic [NUM_NEURONS-1:0]    mode_q, mode_d;
`ifdef MEMBRANE_READBACK_EN
    logic [32*NUM_NEURONS-1:0] v_q, v_d;
`endif

    function automatic logic [31:0] reg_addr(input logic [IDX_W-1:0] idx, input logic [5:0] ofs);
        logic [31:0] off;
        off = '0;
        off[IDX_W+5:6] = idx;
        off[5:0] = ofs;
        return BASE_ADDR + off;
    endfunction

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        poll_d    = poll_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        spike_d   = spike_q;
        timeout_d = timeout_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        re_d      = re_q;
        cur_d     = cur_q;
        mode_d    = mode_q;
`ifdef MEMBRANE_READBACK_EN
        v_d       = v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d     = input_currents;
                    mode_d    = mode_bits;
                    spike_d   = '0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
`ifdef MEMBRANE_READBACK_EN
                    v_d       = '0;
`endif
                    we_d      = 1'b1;
                    addr_d    = reg_addr('0, OFS_I);
                    wdata_d   = input_currents[31:0];
                    state_d   = S_WR_I;
                end
            end
            S_WR_I: begin
                if (!busywait) begin
                    we_d    = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                we_d    = 1'b1;
                addr_d  = reg_addr(idx_q, OFS_CTL);
                wdata_d = {29'b0, mode_q[idx_q], 1'b0, 1'b1};
                state_d = S_WR_CTL;
            end
            S_WR_CTL: begin
                if (!busywait) begin
                    we_d     = 1'b0;
                    settle_d = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == 16'd0) begin
                    re_d    = 1'b1;
                    addr_d  = reg_addr(idx_q, OFS_STAT);
                    poll_d  = POLL_LOAD;
                    state_d = S_POLL;
                end else begin
                    settle_d = settle_q - 16'd1;
                end
            end
            S_POLL: begin
                // re_q low here is the mandatory gap cycle between status reads.
                if (!re_q) begin
                    re_d = 1'b1;
                end else if (!busywait) begin
                    re_d = 1'b0;
                    if (!read_data[1]) begin
                        spike_d[idx_q] = read_data[0];
`ifdef MEMBRANE_READBACK_EN
                        state_d = S_RD_V;
`else
                        state_d = S_NEXT;
`endif
                    end else if (poll_q <= 16'd1) begin
                        timeout_d      = 1'b1;
                        spike_d[idx_q] = 1'b0;
                        state_d        = S_NEXT;
                    end else begin
                        poll_d = poll_q - 16'd1;
                    end
                end
            end
`ifdef MEMBRANE_READBACK_EN
            S_RD_V: begin
                if (!re_q) begin
                    re_d   = 1'b1;
                    addr_d = reg_addr(idx_q, OFS_V);
                end else if (!busywait) begin
                    re_d                 = 1'b0;
                    v_d[idx_q*32 +: 32]  = read_data;
                    state_d              = S_NEXT;
                end
            end
`endif
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_inc;
                    we_d    = 1'b1;
                    addr_d  = reg_addr(idx_inc, OFS_I);
                    wdata_d = cur_q[idx_inc*32 +: 32];
                    state_d = S_WR_I;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            settle_q  <= '0;
            poll_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spike_q   <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            cur_q     <= '0;
            mode_q    <= '0;
`ifdef MEMBRANE_READBACK_EN
            v_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            poll_q    <= poll_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            spike_q   <= spike_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            cur_q     <= cur_d;
            mode_q    <= mode_d;
`ifdef MEMBRANE_READBACK_EN
            v_q       <= v_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign spike_vector = spike_q;
    assign timeout_err  = timeout_q;
    assign addr         = addr_q;
    assign write_en     = we_q;
    assign write_data   = wdata_q;
    assign read_en      = re_q;

`ifdef MEMBRANE_READBACK_EN
    assign v_snapshot = v_q;
`else
    logic unused_rd_bits;
    assign unused_rd_bits = ^read_data[31:2];
    assign v_snapshot     = '0;
`endif

endmodule

// File: tb/tb_neuron_step_sequencer.sv
// Self-checking bench for neuron_step_sequencer: table-driven timesteps with a bus slave model
// and scoreboard queues for bus writes and per-step results.
`timescale 1ns/1ps
module tb_neuron_step_sequencer;
    localparam int POLL_LIM = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] input_currents = '0;
    logic [3:0]   mode_bits = '0;
    logic         busy, done, timeout_err;
    logic [3:0]   spike_vector;
    logic [31:0]  addr, write_data, read_data;
    logic         write_en, read_en, busywait;
    logic [127:0] v_snapshot;

    neuron_step_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .input_currents(input_currents),
        .mode_bits(mode_bits), .busy(busy), .done(done), .spike_vector(spike_vector),
        .timeout_err(timeout_err), .addr(addr), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(read_data), .busywait(busywait), .v_snapshot(v_snapshot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] cur;
        logic [3:0]   mode;
        logic [63:0]  br;      // busy status reads per neuron, 16 bits each
        logic [3:0]   spk;
        int           stall;
        logic [3:0]   exp_spk;
        logic         exp_to;
    } vec_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [3:0] spk; logic to; int lat; logic [127:0] v; int t0; } res_t;

    int total = 0, bad = 0;
    int cyc = 0, done_cnt = 0, viol = 0;
    wr_t  wq[$];
    res_t rq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] vfun(input int n);
        return (n == 1) ? 32'hFFFF_FF9C : 32'(32'h100 * (n + 1) + 32'h5A);
    endfunction

    function automatic int poll_reads(input int br);
        return (br + 1 > POLL_LIM) ? POLL_LIM : br + 1;
    endfunction

    function automatic int exp_lat(input vec_t v);
        int t, br, r;
        t = 1;
        for (int i = 0; i < 4; i++) begin
            br = int'(v.br[16*i +: 16]);
            r  = poll_reads(br);
            t += 2 * (1 + v.stall) + 1 + 2 + r * (1 + v.stall) + (r - 1) + 1;
`ifdef MEMBRANE_READBACK_EN
            if (br < POLL_LIM) t += 2 + v.stall;
`endif
        end
        return t;
    endfunction

    function automatic logic [127:0] exp_v(input vec_t v);
        logic [127:0] e;
        e = '0;
        for (int i = 0; i < 4; i++)
            if (int'(v.br[16*i +: 16]) < POLL_LIM) e[32*i +: 32] = vfun(i);
`ifndef MEMBRANE_READBACK_EN
        e = '0;
`endif
        return e;
    endfunction

    // Slave model: programmable stall per beat, status busy for a set number of reads.
    int          stall_cfg = 0, stall_cnt = 0;
    int          busy_reads[4] = '{0, 0, 0, 0};
    int          rd_seen[4] = '{0, 0, 0, 0};
    int          rd_base[4] = '{0, 0, 0, 0};
    logic [31:0] vval[4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [3:0]  spk = '0;
    logic [1:0]  ridx;
    int          rk;

    assign busywait = (write_en || read_en) && (stall_cnt != stall_cfg);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!(write_en || read_en) || !busywait) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
        if (read_en && !busywait && addr[5:0] == 6'h1C) rd_seen[addr[7:6]] <= rd_seen[addr[7:6]] + 1;
    end

    always_comb begin
        ridx      = addr[7:6];
        rk        = rd_seen[ridx] - rd_base[ridx];
        read_data = 32'hDEAD_0000;
        if (addr[5:0] == 6'h1C) begin
            if (rk < busy_reads[ridx]) read_data = {30'h0, 1'b1, ~spk[ridx]};
            else read_data = {30'h0, 1'b0, spk[ridx]};
        end else if (addr[5:0] == 6'h20) begin
            read_data = vval[ridx];
        end
    end

    // Monitor: bus protocol, write scoreboard, result scoreboard.
    logic        prev_cmp = 1'b0, prev_stall = 1'b0;
    logic [65:0] prev_bus = '0;
    always @(negedge clk) begin : mon
        wr_t  w;
        res_t r;
        if (!rst) begin
            prev_cmp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (write_en && read_en) viol++;
            if (prev_cmp && (write_en || read_en)) viol++;
            if (prev_stall && ({write_en, read_en, addr, write_data} != prev_bus)) viol++;
            prev_bus   = {write_en, read_en, addr, write_data};
            prev_stall = (write_en || read_en) && busywait;
            prev_cmp   = (write_en || read_en) && !busywait;
            if (write_en && !busywait) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr=%h data=%h with none expected", addr, write_data);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", addr, w.a);
                    chk($sformatf("wr_data@%h", w.a), write_data, w.d);
                end
            end
            if (done) begin
                done_cnt++;
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: done at cycle %0d with no step pending", cyc);
                end else begin
                    r = rq.pop_front();
                    chk("spike_vector", spike_vector, r.spk);
                    chk("timeout_err", timeout_err, r.to);
                    chk("latency", cyc - r.t0, r.lat);
                    chk("v_snapshot", v_snapshot, r.v);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    task automatic run_row(input int id, input vec_t v, input bit start_twice, input bit start_at_done);
        res_t r;
        wr_t  w;
        int   d0, v0, n;
        wq.delete();
        rq.delete();
        for (int i = 0; i < 4; i++) begin
            busy_reads[i] = int'(v.br[16*i +: 16]);
            rd_base[i]    = rd_seen[i];
            vval[i]       = vfun(i);
            w.a = 32'(i * 64 + 'h14); w.d = v.cur[32*i +: 32]; wq.push_back(w);
            w.a = 32'(i * 64 + 'h18); w.d = {29'b0, v.mode[i], 2'b01}; wq.push_back(w);
        end
        spk = v.spk; stall_cfg = v.stall;
        input_currents = v.cur; mode_bits = v.mode;
        r.spk = v.exp_spk; r.to = v.exp_to; r.lat = exp_lat(v); r.v = exp_v(v); r.t0 = cyc;
        rq.push_back(r);
        d0 = done_cnt; v0 = viol;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        input_currents = ~v.cur; mode_bits = ~v.mode;
        n = 0;
        while (!done && n < 6000) begin
            start = start_twice && (n == 10);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL row%0d done_wait: no done within %0d cycles", id, n);
        end
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("row%0d busy_after_done", id), busy, 0);
        repeat (40) @(negedge clk);
        chk($sformatf("row%0d done_count", id), done_cnt - d0, 1);
        chk($sformatf("row%0d writes_left", id), wq.size(), 0);
        chk($sformatf("row%0d bus_protocol", id), viol - v0, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("row%0d poll_reads_n%0d", id, i), rd_seen[i] - rd_base[i],
                poll_reads(int'(v.br[16*i +: 16])));
    endtask

    vec_t tbl[5];

    initial begin
        wr_t w;
        int  d0, n;
        tbl[0] = '{cur: {32'd40, 32'd30, 32'd20, 32'd10}, mode: 4'b0000, br: 64'h0, spk: 4'b1010,
                   stall: 0, exp_spk: 4'b1010, exp_to: 1'b0};
        tbl[1] = '{cur: {32'd40, 32'd30, 32'd20, 32'd10}, mode: 4'b0000, br: 64'h0, spk: 4'b1010,
                   stall: 3, exp_spk: 4'b1010, exp_to: 1'b0};
        tbl[2] = '{cur: {32'd7, 32'd6, 32'd5, 32'd4}, mode: 4'b0000, br: {16'd0, 16'd5, 16'd0, 16'd0},
                   spk: 4'b0100, stall: 0, exp_spk: 4'b0100, exp_to: 1'b0};
        tbl[3] = '{cur: {32'd1, 32'd2, 32'd3, 32'd4}, mode: 4'b0000, br: {16'd0, 16'd0, 16'd0, 16'hFFFF},
                   spk: 4'b1111, stall: 0, exp_spk: 4'b1110, exp_to: 1'b1};
        tbl[4] = '{cur: {32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF}, mode: 4'b0100,
                   br: {16'd2, 16'd0, 16'd1, 16'd0}, spk: 4'b0101, stall: 1, exp_spk: 4'b0101, exp_to: 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike", spike_vector, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_read_en", read_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_v", v_snapshot, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_row(i, tbl[i], i == 1, i == 0);

        // Reset while the control write of neuron 0 is stalled on the bus.
        wq.delete();
        rq.delete();
        stall_cfg = 3;
        for (int i = 0; i < 4; i++) begin
            busy_reads[i] = 0;
            rd_base[i] = rd_seen[i];
        end
        input_currents = {32'd4, 32'd3, 32'd2, 32'd99};
        w.a = 32'h14; w.d = 32'd99; wq.push_back(w);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(write_en && addr[5:0] == 6'h18) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_ctl", write_en && addr[5:0] == 6'h18, 1);
        chk("rst_mid_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_write_en", write_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", addr, 0);
        repeat (2) @(negedge clk);
        chk("rst_mid_writes_left", wq.size(), 0);
        wq.delete();
        rst = 1'b1;
        stall_cfg = 0;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_idle_write_en", write_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_step_sequencer.md
Name: neuron_step_sequencer

Overview:
- Bus initiator that autonomously runs one SNN timestep on a neuron bank over the CPU memory-mapped interface, replacing per-neuron CPU polling.
- On start, for each neuron in turn it writes the input current, writes the control register to trigger an update, waits for the update to finish, and captures the spike flag.
- Sits between the timestep/NoC controller and the neuron bank slave port, muxed with the CPU port.

Parameters:
- NUM_NEURONS, 4, neurons sequenced; the neuron index occupies addr[7:6].
- BASE_ADDR, 32'h0000_0000, bank base address; neuron n base = BASE_ADDR + n*64.
- SETTLE_CYCLES, 2, idle cycles after the control write before the first status poll.
- POLL_LIMIT, 255, maximum status reads per neuron before timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a timestep; ignored while busy=1.
- input_currents  in  32*NUM_NEURONS  current for neuron n at bits [32n+31:32n]; snapshotted at start.
- mode_bits  in  NUM_NEURONS  per-neuron mode, written to control bit 2; snapshotted at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; spike_vector is valid from this cycle.
- spike_vector  out  NUM_NEURONS  spike flag per neuron for the last timestep.
- timeout_err  out  1  sticky; set if any neuron exceeded POLL_LIMIT; cleared on the next accepted start.
- addr  out  32  bus address.
- write_en  out  1  bus write strobe.
- write_data  out  32  bus write data.
- read_en  out  1  bus read strobe.
- read_data  in  32  bus read data; sampled in the completing cycle.
- busywait  in  1  slave stall; a transaction completes in a cycle with busywait=0.
- v_snapshot  out  32*NUM_NEURONS  membrane V per neuron (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, done, timeout_err, write_en and read_en = 0; addr, write_data, spike_vector and v_snapshot = 0; neuron index and counters = 0. A reset mid-timestep drops the strobes immediately and abandons the step; no partial done is produced.
- Bus rules:
  - At most one of write_en/read_en is high.
  - The strobe, addr and write_data are held stable while busywait=1.
  - The strobe is deasserted in the cycle after completion, so exactly one accepted beat occurs per transaction; the slave's control write is pulse-sensitive and must never see a duplicate.
  - Consecutive transactions have at least one idle cycle between them.
- FSM: IDLE -> WR_I -> GAP -> WR_CTL -> SETTLE -> POLL -> (RD_V) -> NEXT -> ... -> DONE -> IDLE.
  - IDLE: on start, snapshot the inputs, clear spike_vector, timeout_err and the index, and set busy.
  - WR_I: write input_currents[n] to base(n)+0x14.
  - GAP: one idle cycle, strobes low.
  - WR_CTL: write {29'b0, mode_bits[n], 1'b0, 1'b1} to base(n)+0x18 (update=1, reset=0).
  - SETTLE: strobes low for SETTLE_CYCLES cycles.
  - POLL: read base(n)+0x1C, one cycle gap between reads.
    - On a completed read with bit1=0 (not busy): spike_vector[n] <= read_data[0].
    - If bit1=1: increment the poll counter; when it reaches POLL_LIMIT, set timeout_err, force spike_vector[n]=0 and advance.
  - NEXT: n <= n+1; if n == NUM_NEURONS-1, go to DONE, else WR_I.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- start while busy=1: ignored, with no queuing. start in the DONE cycle: ignored.
- Address arithmetic: the 32-bit sum wraps modulo 2^32; the index is never out of range.
- Latency with busywait=0, SETTLE_CYCLES=2, first poll not busy:
  - per neuron: WR_I 1 + GAP 1 + WR_CTL 1 + SETTLE 2 + POLL 1 + NEXT 1 = 7 cycles;
  - start to done = 1 + 7*NUM_NEURONS cycles.
- Each busywait stall cycle adds exactly one cycle.

Optional Feature:
- MEMBRANE_READBACK_EN defined: after POLL resolves non-busy, state RD_V reads base(n)+0x20 (with one gap cycle first) into v_snapshot[32n+31:32n]. This adds 2 cycles per neuron. On timeout, RD_V is skipped and the slot is left at 0.
- Not defined: no RD_V state, and v_snapshot is tied to 0.

Test Plan:
- Basic step: NUM_NEURONS=4, busywait=0, currents 10,20,30,40, model status reports spikes on neurons 1 and 3 -> writes observed at 0x14,0x18,0x54,0x58,0x94,0x98,0xD4,0xD8 with data 10,1,20,1,30,1,40,1; done at cycle 29 after start; spike_vector=4'b1010.
- Stalls: busywait=1 for 3 cycles on every transaction -> each write is accepted exactly once (control write count = 4), strobes held stable, done is delayed accordingly, and the results are identical to the basic step.
- Slow neuron: status busy for 5 reads on neuron 2 -> 6 reads at 0x9C, spike captured from the 6th read, timeout_err=0.
- Timeout: POLL_LIMIT=3, neuron 0 is always busy -> 3 reads, timeout_err=1, spike_vector[0]=0, sequencing continues to neuron 3, done asserted.
- Mode/start rules: mode_bits=4'b0100 -> neuron 2 control data = 32'h5. A start pulse mid-step is ignored. rst=0 mid-WR_CTL drops write_en the same cycle and busy=0.
- MEMBRANE_READBACK_EN: V model returns 32'hFFFF_FF9C for neuron 1 -> v_snapshot[63:32]=32'hFFFF_FF9C, and start-to-done = 1+9*4 = 37 cycles.
